// File: rtl/dec_bypass_scoreboard.sv
// Decode-stage operand bypass, load-use/long-latency hazard detection and
// register scoreboard for out-of-order long-latency writeback.
module dec_bypass_scoreboard #(
    parameter int NSTG    = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int MAXLONG = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 dec_valid,
    input  logic                 dec_rs1_en,
    input  logic                 dec_rs2_en,
    input  logic [AW-1:0]        dec_rs1,
    input  logic [AW-1:0]        dec_rs2,
    input  logic                 dec_we,
    input  logic [AW-1:0]        dec_rd,
    input  logic                 dec_long,
    input  logic                 ex_allowin,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NSTG-1:0]      fwd_valid,
    input  logic [NSTG*AW-1:0]   fwd_dest,
    input  logic [NSTG-1:0]      fwd_rdy,
    input  logic [NSTG*XLEN-1:0] fwd_data,
    input  logic                 lwb_valid,
    input  logic [AW-1:0]        lwb_dest,
    input  logic [XLEN-1:0]      lwb_data,
    output logic [XLEN-1:0]      src1_value,
    output logic [XLEN-1:0]      src2_value,
    output logic                 dec_ready_go,
    output logic                 issue_fire,
    output logic [3:0]           long_cnt,
    output logic                 sb_err,
    output logic [31:0]          stall_cycles
);

    localparam int         NREG   = 1 << AW;
    localparam logic [3:0] LP_MAX = 4'(MAXLONG);

    logic [NREG-1:0] r_pending;
    logic [3:0]      r_long_cnt;
    logic            r_sb_err;
    logic [31:0]     r_stall_cycles;

    logic [XLEN:0]   w_res1;
    logic [XLEN:0]   w_res2;
    logic            w_waw;
    logic            w_cap;
    logic            w_ready_go;
    logic            w_fire;
    logic            w_lwb_clr;
    logic            w_lwb_err;
    logic            w_set;
    logic [NREG-1:0] w_pending_nxt;
    logic [3:0]      w_long_cnt_nxt;

    // Returns {hazard, value}; the youngest matching stage decides readiness,
    // so an older ready copy never masks a younger load still in flight.
    function automatic logic [XLEN:0] f_resolve(
        input logic                 en,
        input logic [AW-1:0]        rs,
        input logic [XLEN-1:0]      rf,
        input logic [NSTG-1:0]      fv,
        input logic [NSTG*AW-1:0]   fd,
        input logic [NSTG-1:0]      fr,
        input logic [NSTG*XLEN-1:0] fdat,
        input logic                 lv,
        input logic [AW-1:0]        ld,
        input logic [XLEN-1:0]      ldat,
        input logic [NREG-1:0]      pend
    );
        logic            found;
        logic            yrdy;
        logic            lhit;
        logic            haz;
        logic [XLEN-1:0] val;
        found = 1'b0;
        yrdy  = 1'b1;
        haz   = 1'b0;
        val   = rf;
        lhit  = lv && (ld == rs);
        for (int i = 0; i < NSTG; i++) begin
            if (!found && fv[i] && (fd[i*AW +: AW] == rs)) begin
                found = 1'b1;
                val   = fdat[i*XLEN +: XLEN];
                yrdy  = fr[i];
            end else begin
                found = found;
            end
        end
        if (rs == {AW{1'b0}}) begin
            val = {XLEN{1'b0}};
            haz = 1'b0;
        end else if (found) begin
            haz = en && !yrdy;
        end else if (lhit) begin
            val = ldat;
            haz = 1'b0;
        end else begin
            val = rf;
            haz = en && pend[rs];
        end
        return {haz, val};
    endfunction

    // Operand resolution, issue gating and scoreboard next-state.
    always_comb begin
        w_res1 = f_resolve(dec_rs1_en, dec_rs1, rf_rdata1, fwd_valid, fwd_dest, fwd_rdy,
                           fwd_data, lwb_valid, lwb_dest, lwb_data, r_pending);
        w_res2 = f_resolve(dec_rs2_en, dec_rs2, rf_rdata2, fwd_valid, fwd_dest, fwd_rdy,
                           fwd_data, lwb_valid, lwb_dest, lwb_data, r_pending);
        w_waw      = dec_we && (dec_rd != {AW{1'b0}}) && r_pending[dec_rd];
        w_cap      = dec_long && (r_long_cnt == LP_MAX);
        w_ready_go = !(w_res1[XLEN] || w_res2[XLEN] || w_waw || w_cap);
        w_fire     = dec_valid && w_ready_go && ex_allowin;

        w_lwb_clr = lwb_valid && (lwb_dest != {AW{1'b0}}) && r_pending[lwb_dest];
        w_lwb_err = lwb_valid && !w_lwb_clr;
        w_set     = w_fire && dec_long && dec_we && (dec_rd != {AW{1'b0}});

        // Set and clear never target the same register: WAW blocks issue to a pending one.
        w_pending_nxt  = r_pending;
        w_long_cnt_nxt = r_long_cnt;
        if (w_lwb_clr) begin
            w_pending_nxt[lwb_dest] = 1'b0;
            w_long_cnt_nxt          = w_long_cnt_nxt - 4'd1;
        end else begin
            w_long_cnt_nxt = w_long_cnt_nxt;
        end
        if (w_set) begin
            w_pending_nxt[dec_rd] = 1'b1;
            w_long_cnt_nxt        = w_long_cnt_nxt + 4'd1;
        end else begin
            w_long_cnt_nxt = w_long_cnt_nxt;
        end
    end

    // Scoreboard, error flag and stall counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pending      <= {NREG{1'b0}};
            r_long_cnt     <= 4'd0;
            r_sb_err       <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_long_cnt <= w_long_cnt_nxt;
            if (w_lwb_err) begin
                r_sb_err <= 1'b1;
            end else begin
                r_sb_err <= r_sb_err;
            end
            if (dec_valid && !w_ready_go && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

    assign src1_value   = w_res1[XLEN-1:0];
    assign src2_value   = w_res2[XLEN-1:0];
    assign dec_ready_go = w_ready_go;
    assign issue_fire   = w_fire;
    assign long_cnt     = r_long_cnt;
    assign sb_err       = r_sb_err;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_dec_bypass_scoreboard.sv
// Directed bench for dec_bypass_scoreboard: bypass priority, load-use,
// long-latency scoreboard, capacity, WAW and writeback error cases.
module tb_dec_bypass_scoreboard;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dec_valid, dec_rs1_en, dec_rs2_en, dec_we, dec_long, ex_allowin;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_valid, fwd_rdy;
    logic [14:0] fwd_dest;
    logic [95:0] fwd_data;
    logic        lwb_valid;
    logic [4:0]  lwb_dest;
    logic [31:0] lwb_data;
    logic [31:0] src1_value, src2_value;
    logic        dec_ready_go, issue_fire;
    logic [3:0]  long_cnt;
    logic        sb_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    dec_bypass_scoreboard #(.NSTG(3), .XLEN(32), .AW(5), .MAXLONG(4)) dut (
        .clk(clk), .rstn(rstn), .dec_valid(dec_valid),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_we(dec_we), .dec_rd(dec_rd),
        .dec_long(dec_long), .ex_allowin(ex_allowin),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_rdy(fwd_rdy), .fwd_data(fwd_data),
        .lwb_valid(lwb_valid), .lwb_dest(lwb_dest), .lwb_data(lwb_data),
        .src1_value(src1_value), .src2_value(src2_value),
        .dec_ready_go(dec_ready_go), .issue_fire(issue_fire),
        .long_cnt(long_cnt), .sb_err(sb_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_rs1_en = 1'b0; dec_rs2_en = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_we = 1'b0; dec_rd = 5'd0; dec_long = 1'b0;
        ex_allowin = 1'b1; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
        fwd_valid = 3'b000; fwd_rdy = 3'b111; fwd_dest = 15'd0; fwd_data = 96'd0;
        lwb_valid = 1'b0; lwb_dest = 5'd0; lwb_data = 32'd0;
    endtask

    task automatic long_op(input logic [4:0] rd);
        idle();
        dec_valid = 1'b1; dec_we = 1'b1; dec_long = 1'b1; dec_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        idle();
        lwb_valid = 1'b1; lwb_dest = rd; lwb_data = d;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;

        // Plain regfile read after reset
        dec_valid = 1'b1; dec_rs1_en = 1'b1; dec_rs1 = 5'd5; rf_rdata1 = 32'h11;
        #1;
        chk("rst_src1", src1_value, 32'h11);
        chk("rst_ready", {31'd0, dec_ready_go}, 32'd1);
        chk("rst_fire", {31'd0, issue_fire}, 32'd1);
        chk("rst_cnt", {28'd0, long_cnt}, 32'd0);
        chk("rst_err", {31'd0, sb_err}, 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);

        // Youngest forwarding stage wins over older one
        tick();
        dec_rs1 = 5'd3; rf_rdata1 = 32'h33;
        fwd_valid = 3'b101; fwd_dest = {5'd3, 5'd0, 5'd3};
        fwd_data = {32'hBB, 32'h0, 32'hAA}; fwd_rdy = 3'b111;
        #1;
        chk("fwd_pri", src1_value, 32'hAA);
        chk("fwd_ready", {31'd0, dec_ready_go}, 32'd1);
        fwd_rdy = 3'b110;
        #1;
        chk("loaduse_ready", {31'd0, dec_ready_go}, 32'd0);
        chk("loaduse_fire", {31'd0, issue_fire}, 32'd0);
        tick();
        chk("stall_1", stall_cycles, 32'd1);
        tick();
        chk("stall_2", stall_cycles, 32'd2);

        // Long op to r7, dependent read stalls, then bypasses the writeback
        long_op(5'd7);
        #1;
        chk("long7_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        idle();
        dec_valid = 1'b1; dec_rs1_en = 1'b1; dec_rs1 = 5'd7; rf_rdata1 = 32'h55;
        dec_rs2_en = 1'b1; dec_rs2 = 5'd7; rf_rdata2 = 32'h99;
        #1;
        chk("long7_cnt", {28'd0, long_cnt}, 32'd1);
        chk("r7_stall", {31'd0, dec_ready_go}, 32'd0);
        tick();
        chk("stall_3", stall_cycles, 32'd3);
        lwb_valid = 1'b1; lwb_dest = 5'd7; lwb_data = 32'h1234;
        #1;
        chk("lwb_src1", src1_value, 32'h1234);
        chk("lwb_src2", src2_value, 32'h1234);
        chk("lwb_ready", {31'd0, dec_ready_go}, 32'd1);
        tick();
        lwb_valid = 1'b0;
        #1;
        chk("lwb_cnt0", {28'd0, long_cnt}, 32'd0);
        chk("r7_rf", src1_value, 32'h55);
        chk("r7_ready", {31'd0, dec_ready_go}, 32'd1);

        // Fill to capacity
        for (int r = 1; r <= 4; r++) begin
            tick();
            long_op(5'(r));
            #1;
            chk("fill_ready", {31'd0, dec_ready_go}, 32'd1);
        end
        tick();
        long_op(5'd5);
        #1;
        chk("cap_cnt", {28'd0, long_cnt}, 32'd4);
        chk("cap_block", {31'd0, dec_ready_go}, 32'd0);
        tick();
        lwb_valid = 1'b1; lwb_dest = 5'd1; lwb_data = 32'h1;
        #1;
        chk("cap_same_lwb", {31'd0, dec_ready_go}, 32'd0);
        tick();
        lwb_valid = 1'b0;
        #1;
        chk("cap_freed_cnt", {28'd0, long_cnt}, 32'd3);
        chk("cap_issue", {31'd0, issue_fire}, 32'd1);
        chk("stall_5", stall_cycles, 32'd5);
        tick();
        chk("cap_full_again", {28'd0, long_cnt}, 32'd4);

        // Drain r2..r5
        for (int r = 2; r <= 5; r++) begin
            wb(5'(r), 32'(r));
            tick();
        end
        idle();
        #1;
        chk("drain_cnt", {28'd0, long_cnt}, 32'd0);
        chk("drain_err", {31'd0, sb_err}, 32'd0);

        // WAW is conservative against a same-cycle writeback
        long_op(5'd9);
        tick();
        idle();
        dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd9;
        lwb_valid = 1'b1; lwb_dest = 5'd9; lwb_data = 32'h9;
        #1;
        chk("waw_block", {31'd0, dec_ready_go}, 32'd0);
        tick();
        lwb_valid = 1'b0;
        #1;
        chk("waw_cnt", {28'd0, long_cnt}, 32'd0);
        chk("waw_issue", {31'd0, issue_fire}, 32'd1);
        tick();

        // Writeback to a non-pending register is an error, sticky
        wb(5'd12, 32'hC);
        tick();
        idle();
        #1;
        chk("err_set", {31'd0, sb_err}, 32'd1);
        chk("err_cnt", {28'd0, long_cnt}, 32'd0);
        tick();
        chk("err_sticky", {31'd0, sb_err}, 32'd1);

        // Register 0 always reads zero and never hazards
        dec_valid = 1'b1; dec_rs1_en = 1'b1; dec_rs2_en = 1'b1;
        rf_rdata1 = 32'h77; rf_rdata2 = 32'h78;
        fwd_valid = 3'b001; fwd_dest = 15'd0; fwd_data = {64'd0, 32'hDEAD}; fwd_rdy = 3'b110;
        #1;
        chk("r0_src1", src1_value, 32'd0);
        chk("r0_src2", src2_value, 32'd0);
        chk("r0_ready", {31'd0, dec_ready_go}, 32'd1);

        // Reset mid-operation, late writeback flags error
        tick();
        long_op(5'd10);
        tick();
        idle();
        #1;
        chk("pre_rst_cnt", {28'd0, long_cnt}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("mid_rst_cnt", {28'd0, long_cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, sb_err}, 32'd0);
        chk("mid_rst_stall", stall_cycles, 32'd0);
        wb(5'd10, 32'hA);
        tick();
        idle();
        #1;
        chk("late_wb_err", {31'd0, sb_err}, 32'd1);
        chk("late_wb_cnt", {28'd0, long_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
